// File: rtl/de2_115_web_qsys_key_in_if.sv
// Avalon-MM slave bus used by the key/switch input PIO.
//
// Bus signals:
//   address     word address (0 data, 1 reserved, 2 irq mask, 3 edge capture)
//   chipselect  slave select
//   write_n     active-low write strobe, valid only together with chipselect
//   writedata   write data, low WIDTH bits meaningful to the slave
//   readdata    combinational read data, zero-extended above WIDTH
//
// Transfer semantics: a write is accepted on the posedge where
// chipselect=1 and write_n=0. There are no wait states, so the master never
// stalls. readdata always reflects the currently addressed register with no
// side effects; the fabric decides when a read is actually taking place.
interface de2_115_web_qsys_key_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/de2_115_web_qsys_key_in.sv
// Input PIO for the DE2-115 push-buttons and switches.
// Synchronises an asynchronous input bus, captures per-bit edges into a
// sticky register and raises a maskable level interrupt.
//
// Ports:
//   clk      system clock, all logic on posedge
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port  asynchronous external inputs, WIDTH bits
//   irq      active-high level interrupt = |(edge_capture & irq_mask)
module de2_115_web_qsys_key_in #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    de2_115_web_qsys_key_in_if.slave       bus,
    input  logic [WIDTH-1:0]               in_port,
    output logic                           irq
);

    // Counter saturates at SYNC_STAGES+1, which is at most 5.
    localparam logic [2:0] CNT_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clear_bits;
    logic [WIDTH-1:0] capture_next;
    logic [2:0]       start_cnt;
    logic             blank_done;
    logic             wr;
    logic [31:0]      rd;
    logic             unused_wdata;

    // Upper writedata bits are intentionally ignored.
    assign unused_wdata = ^bus.writedata;

    // Synchroniser chain; sync is the last stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Edge detection on the synchronised value against its one-cycle delay.
    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            0:       edges = sync & ~prev;
            1:       edges = ~sync & prev;
            default: edges = sync ^ prev;
        endcase
    end

    // Blanking: the reset values of the sync chain and prev are zero, so the
    // first SYNC_STAGES+1 clocks after release can show edges that never
    // happened on the pins. Captures stay disabled until the counter saturates.
    assign blank_done = (start_cnt == CNT_MAX);

    assign wr         = bus.chipselect & ~bus.write_n;
    assign clear_bits = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    // A new edge overrides a clear on the same bit so no edge is ever lost.
    assign capture_next = (edge_capture & ~clear_bits) | (blank_done ? edges : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            start_cnt    <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            prev         <= sync;
            edge_capture <= capture_next;
            if (!blank_done) start_cnt <= start_cnt + 3'd1;
            if (wr && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    // Combinational, side-effect-free read mux.
    always_comb begin
        rd = '0;
        case (bus.address)
            2'd0:    rd[WIDTH-1:0] = sync;
            2'd2:    rd[WIDTH-1:0] = irq_mask;
            2'd3:    rd[WIDTH-1:0] = edge_capture;
            default: rd = '0;
        endcase
    end

    assign bus.readdata = rd;
    assign irq          = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_de2_115_web_qsys_key_in.sv
// Bench for the key input PIO. Three instances (rising, falling, any edge)
// share clock, reset, in_port and bus stimulus; each is checked every cycle
// against a queue-based model plus directed literal expectations.
module tb_de2_115_web_qsys_key_in;
    localparam int S = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic        irq_r, irq_f, irq_a;

    de2_115_web_qsys_key_in_if bus_r ();
    de2_115_web_qsys_key_in_if bus_f ();
    de2_115_web_qsys_key_in_if bus_a ();

    assign bus_r.address = address;  assign bus_r.chipselect = chipselect;
    assign bus_r.write_n = write_n;  assign bus_r.writedata  = writedata;
    assign bus_f.address = address;  assign bus_f.chipselect = chipselect;
    assign bus_f.write_n = write_n;  assign bus_f.writedata  = writedata;
    assign bus_a.address = address;  assign bus_a.chipselect = chipselect;
    assign bus_a.write_n = write_n;  assign bus_a.writedata  = writedata;

    de2_115_web_qsys_key_in #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
        .clk(clk), .reset_n(reset_n), .bus(bus_r.slave), .in_port(in_port), .irq(irq_r));
    de2_115_web_qsys_key_in #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_fall (
        .clk(clk), .reset_n(reset_n), .bus(bus_f.slave), .in_port(in_port), .irq(irq_f));
    de2_115_web_qsys_key_in #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .in_port(in_port), .irq(irq_a));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // hist holds in_port as sampled on recent clock edges (newest at back).
    // The synchronised value is the sample taken S edges ago; an edge is a
    // difference between that and the sample one edge older.
    logic [3:0] hist[$];
    int         n_edges;
    logic [3:0] m_cap[3];
    logic [3:0] m_mask[3];

    function automatic logic [3:0] m_sync();
        return (hist.size() >= S) ? hist[hist.size()-S] : 4'h0;
    endfunction

    function automatic logic [3:0] m_prev();
        return (hist.size() >= S + 1) ? hist[hist.size()-S-1] : 4'h0;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_sync()};
            2'd2:    return {28'h0, m_mask[k]};
            2'd3:    return {28'h0, m_cap[k]};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        hist.delete();
        n_edges = 0;
        for (int k = 0; k < 3; k++) begin m_cap[k] = '0; m_mask[k] = '0; end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                hist.delete();
                n_edges = 0;
                for (int k = 0; k < 3; k++) begin m_cap[k] = '0; m_mask[k] = '0; end
            end else begin
                logic [3:0] s, p, clr;
                logic [3:0] det[3];
                s = m_sync();
                p = m_prev();
                det[0] = s & ~p;
                det[1] = ~s & p;
                det[2] = s ^ p;
                clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
                for (int k = 0; k < 3; k++) begin
                    m_cap[k] = (m_cap[k] & ~clr) | ((n_edges >= S + 1) ? det[k] : 4'h0);
                    if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata[3:0];
                end
                hist.push_back(in_port);
                if (hist.size() > S + 1) void'(hist.pop_front());
                if (n_edges < 1000) n_edges++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("rd_rise", bus_r.readdata, m_read(0, address));
            check("rd_fall", bus_f.readdata, m_read(1, address));
            check("rd_any",  bus_a.readdata, m_read(2, address));
            check("irq_rise", {31'h0, irq_r}, {31'h0, |(m_cap[0] & m_mask[0])});
            check("irq_fall", {31'h0, irq_f}, {31'h0, |(m_cap[1] & m_mask[1])});
            check("irq_any",  {31'h0, irq_a}, {31'h0, |(m_cap[2] & m_mask[2])});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a,
                              input logic [31:0] act_sel, input logic [31:0] exp);
        check(name, act_sel, exp);
        address = a;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0; in_port = 4'hF;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();

        // 1: inputs asserted through reset give no captures
        address = 2'd3; #1;
        check("t1_cap_rise", bus_r.readdata, 32'h0);
        check("t1_cap_fall", bus_f.readdata, 32'h0);
        check("t1_cap_any",  bus_a.readdata, 32'h0);
        check("t1_irq_any",  {31'h0, irq_a}, 32'h0);
        address = 2'd0; #1;
        check("t1_data", bus_f.readdata, 32'hF);

        // 2: falling edge on bit0 captured exactly S+1 clocks later
        bus_write(2'd2, 32'h1);
        in_port = 4'hE; address = 2'd3; #1;
        check("t2_clk0", bus_f.readdata, 32'h0);
        tick(); #1; check("t2_clk1", bus_f.readdata, 32'h0);
        tick(); #1; check("t2_clk2", bus_f.readdata, 32'h0);
        tick(); #1; check("t2_clk3", bus_f.readdata, 32'h1);
        check("t2_irq", {31'h0, irq_f}, 32'h1);
        check("t2_rise_none", bus_r.readdata, 32'h0);

        // 3: clear, then masked capture keeps irq low
        bus_write(2'd3, 32'h1);
        address = 2'd3; #1;
        check("t3_cleared", bus_f.readdata, 32'h0);
        check("t3_irq_low", {31'h0, irq_f}, 32'h0);
        bus_write(2'd2, 32'h0);
        in_port = 4'hC;
        repeat (4) tick();
        address = 2'd3; #1;
        check("t3_masked_cap", bus_f.readdata, 32'h2);
        check("t3_masked_irq", {31'h0, irq_f}, 32'h0);
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'hF);

        // 4: edge on bit2 lands in the same cycle as its clear
        in_port = 4'h8;
        tick(); tick();
        bus_write(2'd3, 32'h4);
        address = 2'd3; #1;
        check("t4_set_wins", bus_f.readdata, 32'h4);
        check("t4_irq", {31'h0, irq_f}, 32'h1);
        bus_write(2'd3, 32'hF);

        // 5: bit3 toggles, edge-type comparison
        in_port = 4'h0;
        repeat (4) tick();
        bus_write(2'd3, 32'hF);
        in_port = 4'h8;
        repeat (4) tick();
        address = 2'd3; #1;
        check("t5_up_rise", bus_r.readdata, 32'h8);
        check("t5_up_any",  bus_a.readdata, 32'h8);
        check("t5_up_fall", bus_f.readdata, 32'h0);
        bus_write(2'd3, 32'hF);
        in_port = 4'h0;
        repeat (4) tick();
        address = 2'd3; #1;
        check("t5_dn_rise", bus_r.readdata, 32'h0);
        check("t5_dn_any",  bus_a.readdata, 32'h8);
        check("t5_dn_fall", bus_f.readdata, 32'h8);
        bus_write(2'd3, 32'hF);

        // 6: reset while irq is high, blanking after release
        in_port = 4'h8;
        repeat (4) tick();
        #1; check("t6_irq_before", {31'h0, irq_r}, 32'h1);
        reset_n = 1'b0; #1;
        check("t6_irq_reset", {31'h0, irq_r}, 32'h0);
        address = 2'd2; #1; check("t6_mask_reset", bus_r.readdata, 32'h0);
        address = 2'd3; #1; check("t6_cap_reset", bus_r.readdata, 32'h0);
        address = 2'd0; #1; check("t6_data_reset", bus_r.readdata, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        address = 2'd3; #1;
        check("t6_blank_rise", bus_r.readdata, 32'h0);
        check("t6_blank_any",  bus_a.readdata, 32'h0);
        bus_write(2'd2, 32'hF);
        #1; check("t6_irq_after", {31'h0, irq_r}, 32'h0);
        in_port = 4'h0;
        repeat (4) tick();
        address = 2'd3; #1;
        check("t6_fall_live", bus_f.readdata, 32'h8);
        check("t6_fall_irq", {31'h0, irq_f}, 32'h1);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
